// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types for the data-memory responder.
//   mr_state_t : responder FSM state (idle / array read in flight / response cycle)
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_READ = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: circular store buffer with a combinational youngest-match lookup.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   push/push_idx/push_data  enqueue an entry at the tail
//   pop                   dequeue the head entry
//   full, empty, count    occupancy (registered)
//   head_idx, head_data   oldest entry
//   lookup_idx            word index to search for
//   hit, hit_data         youngest valid entry whose index matches lookup_idx
module wbuf_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned DWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [IDX_W-1:0]         push_idx,
    input  logic [DWIDTH-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [IDX_W-1:0]         head_idx,
    output logic [DWIDTH-1:0]        head_data,
    input  logic [IDX_W-1:0]         lookup_idx,
    output logic                     hit,
    output logic [DWIDTH-1:0]        hit_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [DWIDTH-1:0] data_q [DEPTH];

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_idx  = idx_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // increments wrap modulo DEPTH without extra logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wr_ptr_q]  <= push_idx;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // Walk from oldest to youngest; a later match overrides an earlier one,
    // leaving the youngest matching entry in hit_data.
    always_comb begin
        logic [PTR_W-1:0] pos;
        hit      = 1'b0;
        hit_data = '0;
        pos      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            pos = rd_ptr_q + PTR_W'(k);
            if ((k < 32'(count_q)) && (idx_q[pos] == lookup_idx)) begin
                hit      = 1'b1;
                hit_data = data_q[pos];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder for MEM-stage data-memory loads and stores.
// Word array with a multi-cycle read latency, fronted by a write buffer that
// retires stores in one cycle and forwards buffered data to later loads.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   req_valid, req_we     request present / store (1) or load (0)
//   req_addr, req_wdata   byte address, store data
//   req_ready             request accepted at this edge when req_valid & req_ready
//   stall                 req_valid & ~req_ready, consumed by hazard_ctrl
//   resp_valid            one-cycle load response pulse
//   resp_rdata            load data, valid with resp_valid
//   err                   one-cycle pulse for a misaligned or out-of-range request
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_SIZE   = 64,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              err
);

    localparam int unsigned IDX_W   = $clog2(MEM_SIZE);
    localparam int unsigned LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WCNT_W  = $clog2(WBUF_DEPTH) + 1;

    mr_state_t         state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] mem_q [MEM_SIZE];

    logic [IDX_W-1:0]  req_idx;
    logic              req_bad;
    logic              accept;

    logic              wb_push;
    logic              wb_pop;
    logic              wb_full;
    logic              wb_empty;
    logic [WCNT_W-1:0] wb_count;
    logic [IDX_W-1:0]  wb_head_idx;
    logic [DWIDTH-1:0] wb_head_data;
    logic              wb_hit;
    logic [DWIDTH-1:0] wb_hit_data;

    assign req_idx = req_addr[IDX_W+1:2];
    assign req_bad = (|req_addr[1:0]) | (|req_addr[DWIDTH-1:IDX_W+2]);

    // Registered occupancy only: a pop in the same cycle does not free a slot.
    assign req_ready = (state_q == MR_IDLE) & (~req_we | (wb_count < WCNT_W'(WBUF_DEPTH)));
    assign stall     = req_valid & ~req_ready;
    assign accept    = req_valid & req_ready;

    // The array read in MR_READ must see a stable array, so draining waits.
    assign wb_pop = ~wb_empty & (state_q != MR_READ);

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign err        = err_q;

    wbuf_fifo #(
        .DEPTH  (WBUF_DEPTH),
        .IDX_W  (IDX_W),
        .DWIDTH (DWIDTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (wb_push),
        .push_idx   (req_idx),
        .push_data  (req_wdata),
        .pop        (wb_pop),
        .full       (wb_full),
        .empty      (wb_empty),
        .count      (wb_count),
        .head_idx   (wb_head_idx),
        .head_data  (wb_head_data),
        .lookup_idx (req_idx),
        .hit        (wb_hit),
        .hit_data   (wb_hit_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_idx_d     = rd_idx_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        err_d        = 1'b0;
        wb_push      = 1'b0;
        unique case (state_q)
            MR_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                        if (!req_we) begin
                            resp_rdata_d = '0;
                            resp_valid_d = 1'b1;
                            state_d      = MR_RESP;
                        end
                    end else if (req_we) begin
                        // wb_full is already excluded by req_ready; kept as a guard.
                        wb_push = ~wb_full;
                    end else if (wb_hit) begin
                        resp_rdata_d = wb_hit_data;
                        resp_valid_d = 1'b1;
                        state_d      = MR_RESP;
                    end else begin
                        cnt_d    = LAT_W'(LATENCY - 1);
                        rd_idx_d = req_idx;
                        state_d  = MR_READ;
                    end
                end
            end
            MR_READ: begin
                if (cnt_q == '0) begin
                    resp_rdata_d = mem_q[rd_idx_q];
                    resp_valid_d = 1'b1;
                    state_d      = MR_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            MR_RESP: begin
                state_d = MR_IDLE;
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= MR_IDLE;
            cnt_q        <= '0;
            rd_idx_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_idx_q     <= rd_idx_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_pop) begin
            mem_q[wb_head_idx] <= wb_head_data;
        end
    end

endmodule
